datapath: RTL and testbench

- Single-bus 32-bit CPU datapath: general registers R2/R4/R5, PC, IR, MAR, MDR, HI, LO, Y and a 64-bit Z (Zhi:Zlo), joined by one shared 32-bit bus and one ALU.
- Driven cycle by cycle by an external control unit (or a bench) through per-register in/out strobes and one-hot ALU op selects.
- The 64-bit Z value is exported for observation.

---
 rtl/datapath_pkg.sv | 40 ++++
 rtl/datapath_alu.sv | 78 +++++++
 rtl/datapath.sv | 148 ++++++++++++++
 tb/tb_datapath.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the single-bus CPU datapath.
//   DATA_W    default bus/register width
//   alu_op_e  one-hot ALU op select index (bit position in the op vector,
//             lowest index has highest priority)
//   bus_src_e bus source index (lowest index has highest priority)
package datapath_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_ROR = 4'd8,
    OP_ROL = 4'd9,
    OP_NEG = 4'd10,
    OP_NOT = 4'd11
  } alu_op_e;

  localparam int N_OPS = 12;

  typedef enum logic [2:0] {
    SRC_MDR = 3'd0,
    SRC_PC  = 3'd1,
    SRC_ZLO = 3'd2,
    SRC_ZHI = 3'd3,
    SRC_HI  = 3'd4,
    SRC_LO  = 3'd5,
    SRC_R2  = 3'd6,
    SRC_R4  = 3'd7
  } bus_src_e;

  localparam int N_SRC = 8;

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU of the single-bus datapath.
//   a       operand A (Y register)
//   b       operand B (bus)
//   op      one-hot op selects, indexed by alu_op_e; lowest set index wins
//   inc_pc  forces c = b + 1 (zero-extended), overriding every op select
//   c       64-bit result (loaded into Z)
// Optional feature macro: DATAPATH_MULDIV_EN builds the signed multiplier and
// divider; without it MUL/DIV selects are ignored and priority falls through.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [N_OPS-1:0]   op,
  input  logic               inc_pc,
  output logic [2*WIDTH-1:0] c
);

  localparam int SH_W = $clog2(WIDTH);

  function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   sum, diff, incr;
  logic [2*WIDTH-1:0] rot_r, rot_l;

  assign shamt = b[SH_W-1:0];
  assign sum   = a + b;
  assign diff  = a - b;
  assign incr  = b + WIDTH'(1);
  // Rotates via a doubled copy of A so no out-of-range shift is needed.
  assign rot_r = {a, a} >> shamt;
  assign rot_l = {a, a} << shamt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [2*WIDTH-1:0] a_wide, b_wide, prod;
  logic signed [WIDTH-1:0]   quo, rem;

  // Sign-extend both operands to full width so the low 2*WIDTH bits of the
  // product are the exact signed product.
  assign a_wide = $signed(sext(a));
  assign b_wide = $signed(sext(b));
  assign prod   = a_wide * b_wide;
  assign quo    = (b == '0) ? '0 : $signed(a) / $signed(b);
  assign rem    = (b == '0) ? '0 : $signed(a) % $signed(b);
`else
  logic unused_muldiv;
  assign unused_muldiv = op[OP_MUL] ^ op[OP_DIV];
`endif

  always_comb begin
    c = sext(b);
    if (inc_pc)               c = zext(incr);
    else if (op[OP_AND])      c = zext(a & b);
    else if (op[OP_OR])       c = zext(a | b);
    else if (op[OP_ADD])      c = sext(sum);
    else if (op[OP_SUB])      c = sext(diff);
`ifdef DATAPATH_MULDIV_EN
    else if (op[OP_MUL])      c = prod;
    else if (op[OP_DIV])      c = {rem, quo};
`endif
    else if (op[OP_SHR])      c = zext(a >> shamt);
    else if (op[OP_SHL])      c = zext(a << shamt);
    else if (op[OP_ROR])      c = zext(rot_r[WIDTH-1:0]);
    else if (op[OP_ROL])      c = zext(rot_l[2*WIDTH-1:WIDTH]);
    else if (op[OP_NEG])      c = sext(-b);
    else if (op[OP_NOT])      c = sext(~b);
  end

endmodule

// File: rtl/datapath.sv
// datapath: single-bus 32-bit CPU datapath (R2/R4/R5, PC, IR, MAR, MDR, HI,
// LO, Y, 64-bit Z) around one shared bus and one ALU.
//   Clock, Clear          rising-edge clock, synchronous active-high reset
//   outp                  current Z register {Zhi, Zlo}
//   *out strobes          bus drivers (priority MDR, PC, Zlo, Zhi, HI, LO, R2, R4)
//   *in strobes           register loads from the bus (MDR may take Mdatain)
//   IncPC, Read           ALU increment override, MDR input select
//   Mdatain               memory read data
//   AND..NOT              one-hot ALU op selects, first in port order wins
// Optional feature macro: DATAPATH_MULDIV_EN (signed MUL/DIV in the ALU).
module datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                      Clock,
  input  logic                      Clear,
  output logic signed [2*WIDTH-1:0] outp,
  input  logic                      PCout,
  input  logic                      Zhiout,
  input  logic                      Zlowout,
  input  logic                      MDRout,
  input  logic                      R2out,
  input  logic                      R4out,
  input  logic                      HIout,
  input  logic                      LOout,
  input  logic                      MARin,
  input  logic                      Zin,
  input  logic                      PCin,
  input  logic                      MDRin,
  input  logic                      IRin,
  input  logic                      Yin,
  input  logic                      HIin,
  input  logic                      LOin,
  input  logic                      IncPC,
  input  logic                      Read,
  input  logic                      R5in,
  input  logic                      R2in,
  input  logic                      R4in,
  input  logic [WIDTH-1:0]          Mdatain,
  input  logic                      AND,
  input  logic                      OR,
  input  logic                      ADD,
  input  logic                      SUB,
  input  logic                      MUL,
  input  logic                      DIV,
  input  logic                      SHR,
  input  logic                      SHL,
  input  logic                      ROR,
  input  logic                      ROL,
  input  logic                      NEG,
  input  logic                      NOT
);

  logic [WIDTH-1:0]   r2_reg, r4_reg, r5_reg, pc_reg, ir_reg, mar_reg;
  logic [WIDTH-1:0]   mdr_reg, hi_reg, lo_reg, y_reg;
  logic [2*WIDTH-1:0] z_reg;
  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_c;
  logic [N_OPS-1:0]   alu_op;

  // Bus source request vector and values, indexed by priority.
  logic [N_SRC-1:0] src_req, src_grant;
  logic [WIDTH-1:0] src_val [N_SRC];

  assign src_req[SRC_MDR] = MDRout;
  assign src_req[SRC_PC]  = PCout;
  assign src_req[SRC_ZLO] = Zlowout;
  assign src_req[SRC_ZHI] = Zhiout;
  assign src_req[SRC_HI]  = HIout;
  assign src_req[SRC_LO]  = LOout;
  assign src_req[SRC_R2]  = R2out;
  assign src_req[SRC_R4]  = R4out;

  assign src_val[SRC_MDR] = mdr_reg;
  assign src_val[SRC_PC]  = pc_reg;
  assign src_val[SRC_ZLO] = z_reg[WIDTH-1:0];
  assign src_val[SRC_ZHI] = z_reg[2*WIDTH-1:WIDTH];
  assign src_val[SRC_HI]  = hi_reg;
  assign src_val[SRC_LO]  = lo_reg;
  assign src_val[SRC_R2]  = r2_reg;
  assign src_val[SRC_R4]  = r4_reg;

  // A source is granted only if no higher-priority (lower index) source asks.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_grant
      if (gi == 0) begin : g_first
        assign src_grant[gi] = src_req[gi];
      end else begin : g_rest
        assign src_grant[gi] = src_req[gi] & ~(|src_req[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    bus = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_grant[i]) bus = bus | src_val[i];
    end
  end

  assign alu_op = {NOT, NEG, ROL, ROR, SHL, SHR, DIV, MUL, SUB, ADD, OR, AND};

  datapath_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (y_reg),
    .b      (bus),
    .op     (alu_op),
    .inc_pc (IncPC),
    .c      (alu_c)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r2_reg  <= '0;
      r4_reg  <= '0;
      r5_reg  <= '0;
      pc_reg  <= '0;
      ir_reg  <= '0;
      mar_reg <= '0;
      mdr_reg <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
      y_reg   <= '0;
      z_reg   <= '0;
    end else begin
      if (R2in)  r2_reg  <= bus;
      if (R4in)  r4_reg  <= bus;
      if (R5in)  r5_reg  <= bus;
      if (PCin)  pc_reg  <= bus;
      if (IRin)  ir_reg  <= bus;
      if (MARin) mar_reg <= bus;
      if (MDRin) mdr_reg <= Read ? Mdatain : bus;
      if (HIin)  hi_reg  <= bus;
      if (LOin)  lo_reg  <= bus;
      if (Yin)   y_reg   <= bus;
      if (Zin)   z_reg   <= alu_c;
    end
  end

  assign outp = $signed(z_reg);

  // MAR, IR and R5 feed the memory interface, the control unit and future
  // bus drivers outside this slice; nothing inside reads them.
  logic unused_internal;
  assign unused_internal = ^{mar_reg, ir_reg, r5_reg};

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic signed [63:0] outp;
  logic PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic IncPC, Read, R5in, R2in, R4in;
  logic [31:0] Mdatain;
  logic [11:0] ops;

  localparam logic [11:0] M_AND = 12'h001, M_OR  = 12'h002, M_ADD = 12'h004,
                          M_SUB = 12'h008, M_MUL = 12'h010, M_DIV = 12'h020,
                          M_SHR = 12'h040, M_SHL = 12'h080, M_ROR = 12'h100,
                          M_ROL = 12'h200, M_NEG = 12'h400, M_NOT = 12'h800;

  localparam int K_Z = 0, K_MAR = 1, K_IR = 2, K_R5 = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;

  datapath dut (
    .Clock(Clock), .Clear(Clear), .outp(outp),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out), .HIout(HIout), .LOout(LOout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .R5in(R5in), .R2in(R2in), .R4in(R4in), .Mdatain(Mdatain),
    .AND(ops[0]), .OR(ops[1]), .ADD(ops[2]), .SUB(ops[3]), .MUL(ops[4]),
    .DIV(ops[5]), .SHR(ops[6]), .SHL(ops[7]), .ROR(ops[8]), .ROL(ops[9]),
    .NEG(ops[10]), .NOT(ops[11])
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      K_MAR:   return {32'h0, dut.mar_reg};
      K_IR:    return {32'h0, dut.ir_reg};
      K_R5:    return {32'h0, dut.r5_reg};
      default: return outp;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Clear = 0;
    {PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin} = '0;
    {IncPC, Read, R5in, R2in, R4in} = '0;
    ops = '0;
  endtask

  task automatic expect_val(input string tag, input int kind, input logic [63:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.kind);
      compared++;
      $display("txn %-12s observed %h expected %h", e.tag, obs, e.exp);
      assert (obs === e.exp) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    idle();
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1;
    tick();
    idle();
  endtask

  // Y = a, bus = MDR = b, ALU result captured in Z.
  task automatic alu_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [11:0] opsv, input logic [63:0] exp);
    set_y(a);
    load_mdr(b);
    MDRout = 1; ops = opsv; Zin = 1;
    expect_val(tag, K_Z, exp);
    tick();
    idle();
    check_all();
  endtask

  initial begin
    idle();
    Mdatain = '0;

    // Reset
    Clear = 1;
    expect_val("rst_z",   K_Z,   64'h0);
    expect_val("rst_mar", K_MAR, 64'h0);
    expect_val("rst_ir",  K_IR,  64'h0);
    expect_val("rst_r5",  K_R5,  64'h0);
    tick(); idle(); check_all();

    // Register loads through MDR
    load_mdr(32'd12); MDRout = 1; R2in = 1; tick(); idle();
    load_mdr(32'd15); MDRout = 1; R4in = 1; tick(); idle();
    load_mdr(32'd10); MDRout = 1; R5in = 1;
    expect_val("r5_load", K_R5, 64'd10);
    tick(); idle(); check_all();

    R2out = 1; Zin = 1; expect_val("r2_load", K_Z, 64'd12);
    tick(); idle(); check_all();
    R4out = 1; Zin = 1; expect_val("r4_load", K_Z, 64'd15);
    tick(); idle(); check_all();
    R2out = 1; R4out = 1; Zin = 1; expect_val("prio_r2_r4", K_Z, 64'd12);
    tick(); idle(); check_all();

    // PC increment
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    expect_val("pc_inc_z",   K_Z,   64'd1);
    expect_val("pc_inc_mar", K_MAR, 64'd0);
    tick(); idle(); check_all();
    Zlowout = 1; PCin = 1; tick(); idle();
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    expect_val("pc_inc2_z",   K_Z,   64'd2);
    expect_val("pc_inc2_mar", K_MAR, 64'd1);
    tick(); idle(); check_all();

    // Instruction fetch
    load_mdr(32'h2292_0000); MDRout = 1; IRin = 1;
    expect_val("ir_fetch", K_IR, 64'h2292_0000);
    tick(); idle(); check_all();

    // Subtract R2 - R4
    R2out = 1; Yin = 1; tick(); idle();
    R4out = 1; ops = M_SUB; Zin = 1;
    expect_val("sub", K_Z, 64'hFFFF_FFFF_FFFF_FFFD);
    tick(); idle(); check_all();
    Zlowout = 1; R5in = 1;
    expect_val("sub_to_r5", K_R5, 64'h0000_0000_FFFF_FFFD);
    tick(); idle(); check_all();

    // ALU ops
    alu_case("add",       32'd12,        32'd15,        M_ADD,         64'd27);
    alu_case("and",       32'd12,        32'd10,        M_AND,         64'd8);
    alu_case("or",        32'd12,        32'd10,        M_OR,          64'd14);
    alu_case("and_or",    32'd12,        32'd10,        M_AND | M_OR,  64'd8);
    alu_case("shr",       32'h8000_0001, 32'd4,         M_SHR,         64'h0800_0000);
    alu_case("shl",       32'h8000_0001, 32'd4,         M_SHL,         64'h0000_0010);
    alu_case("ror",       32'h8000_0001, 32'd4,         M_ROR,         64'h1800_0000);
    alu_case("rol",       32'h8000_0001, 32'd4,         M_ROL,         64'h0000_0018);
    alu_case("shr_amt5",  32'h8000_0000, 32'h24,        M_SHR,         64'h0800_0000);
    alu_case("neg",       32'd0,         32'd4,         M_NEG,         64'hFFFF_FFFF_FFFF_FFFC);
    alu_case("not",       32'd0,         32'd4,         M_NOT,         64'hFFFF_FFFF_FFFF_FFFB);
    alu_case("pass_sext", 32'd0,         32'h8000_0000, 12'h000,       64'hFFFF_FFFF_8000_0000);
    alu_case("sub_neg",   32'd5,         32'd3,         M_SUB | M_NEG, 64'd2);
    alu_case("inc_prio",  32'd5,         32'h7FFF_FFFF, 12'h000,       64'hFFFF_FFFF_FFFF_FFFF - 64'hFFFF_FFFF_8000_0000 + 64'h0);
    set_y(32'd5); load_mdr(32'h7FFF_FFFF);
    MDRout = 1; IncPC = 1; ops = M_SUB; Zin = 1;
    expect_val("incpc_zext", K_Z, 64'h0000_0000_8000_0000);
    tick(); idle(); check_all();

`ifdef DATAPATH_MULDIV_EN
    alu_case("mul",       32'd6,  32'hFFFF_FFF9, M_MUL,         64'hFFFF_FFFF_FFFF_FFD6);
    alu_case("mul_prio",  32'd6,  32'd4,         M_MUL | M_SHR, 64'd24);
    alu_case("div",       32'd43, 32'hFFFF_FFF9, M_DIV,         64'h0000_0001_FFFF_FFFA);
    alu_case("div0",      32'd43, 32'd0,         M_DIV | M_SHR, 64'd0);
`else
    alu_case("mul",       32'd6,  32'hFFFF_FFF9, M_MUL,         64'hFFFF_FFFF_FFFF_FFF9);
    alu_case("mul_prio",  32'd6,  32'd4,         M_MUL | M_SHR, 64'd0);
    alu_case("div",       32'd43, 32'hFFFF_FFF9, M_DIV,         64'hFFFF_FFFF_FFFF_FFF9);
    alu_case("div0",      32'd43, 32'd0,         M_DIV | M_SHR, 64'd43);
`endif

    // Z halves back onto the bus
    alu_case("add_wrap",  32'h7FFF_FFFF, 32'd1, M_ADD, 64'hFFFF_FFFF_8000_0000);
    Zhiout = 1; Zlowout = 1; Zin = 1;
    expect_val("prio_zlo", K_Z, 64'hFFFF_FFFF_8000_0000);
    tick(); idle(); check_all();
    alu_case("add_small", 32'd3, 32'd4, M_ADD, 64'd7);
    Zhiout = 1; Zin = 1;
    expect_val("zhi_out", K_Z, 64'd0);
    tick(); idle(); check_all();

    // HI / LO and bus priority
    load_mdr(32'd4); MDRout = 1; HIin = 1; tick(); idle();
    load_mdr(32'd9); MDRout = 1; LOin = 1; tick(); idle();
    HIout = 1; LOout = 1; Zin = 1; expect_val("prio_hi_lo", K_Z, 64'd4);
    tick(); idle(); check_all();
    LOout = 1; Zin = 1; expect_val("lo_out", K_Z, 64'd9);
    tick(); idle(); check_all();
    MDRout = 1; HIout = 1; Zin = 1; expect_val("prio_mdr", K_Z, 64'd9);
    tick(); idle(); check_all();
    Zin = 1; expect_val("bus_idle", K_Z, 64'd0);
    tick(); idle(); check_all();

    // Reset in the middle of a transfer
    load_mdr(32'd55);
    MDRout = 1; R5in = 1; Zin = 1; Clear = 1;
    expect_val("clr_z",   K_Z,   64'd0);
    expect_val("clr_r5",  K_R5,  64'd0);
    expect_val("clr_mar", K_MAR, 64'd0);
    expect_val("clr_ir",  K_IR,  64'd0);
    tick(); idle(); check_all();
    PCout = 1; Zin = 1; expect_val("clr_pc", K_Z, 64'd0);
    tick(); idle(); check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
